// File: rtl/std_register_arbiter_pkg.sv
// Shared definitions for the std register arbiter: FSM state encoding and
// the index wrap helper used by the round-robin logic.
package std_pkg;

    typedef enum logic {
        STD_REG_ARB_ARB    = 1'b0,
        STD_REG_ARB_LOCKED = 1'b1
    } std_reg_arb_state_t;

    // Next index after idx, wrapping back to 0 after ports-1.
    function automatic int unsigned std_wrap_inc(input int unsigned idx,
                                                 input int unsigned ports);
        return (idx + 1 >= ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/std_register_arbiter_picker.sv
// Combinational round-robin picker: grants the first set request found by
// searching upward from ptr and wrapping at PORTS-1. Shared by other arbiters.
module std_round_robin_picker #(
    parameter int PORTS     = 4,
    parameter int IDX_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0]     req,
    input  logic [IDX_WIDTH-1:0] ptr,
    input  logic                 enable,
    output logic [PORTS-1:0]     grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 any_grant
);

    // First-hit search over the rotated request vector.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            if (enable && !any_grant && req[(int'(ptr) + k) % PORTS]) begin
                any_grant                        = 1'b1;
                grant_idx                        = IDX_WIDTH'((int'(ptr) + k) % PORTS);
                grant[(int'(ptr) + k) % PORTS]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/std_register_arbiter.sv
// Shared enable-gated register with round-robin write arbitration, an
// atomic lock for multi-cycle sequences and a lock watchdog.
//
//   state              | meaning
//   -------------------+-----------------------------------------------
//   STD_REG_ARB_ARB    | open arbitration, round-robin from ptr
//   STD_REG_ARB_LOCKED | only lock_owner may write; watchdog counting
module std_register_arbiter
    import std_pkg::*;
#(
    parameter int                      PORTS        = 4,
    parameter int                      DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                      LOCK_TIMEOUT = 256,
    parameter int                      IDX_WIDTH    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic [PORTS-1:0]            req_valid,
    input  logic [PORTS-1:0]            req_lock,
    input  logic [PORTS*DATA_WIDTH-1:0] req_data,
    output logic [PORTS-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]       value,
    output logic                        update,
    output logic [IDX_WIDTH-1:0]        writer,
    output logic                        locked,
    output logic [IDX_WIDTH-1:0]        lock_owner,
    output logic                        lock_timeout
);

    localparam bit WD_EN = (LOCK_TIMEOUT > 0);
    // Counter only ever needs to reach LOCK_TIMEOUT-1.
    localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? LOCK_TIMEOUT - 1 : 0);

    std_reg_arb_state_t    state;
    logic [IDX_WIDTH-1:0]  ptr;
    logic [CNT_W-1:0]      cnt;

    logic [PORTS-1:0]      owner_mask;
    logic [PORTS-1:0]      eff_req;
    logic [PORTS-1:0]      grant;
    logic [IDX_WIDTH-1:0]  grant_idx;
    logic                  any_grant;
    logic                  grant_lock;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [IDX_WIDTH-1:0]  ptr_after_grant;
    logic [IDX_WIDTH-1:0]  ptr_after_owner;

    // While locked the owner is the only candidate, so the picker's pointer
    // has no effect and one picker serves both states.
    always_comb begin
        owner_mask      = PORTS'(1) << lock_owner;
        eff_req         = (state == STD_REG_ARB_ARB) ? req_valid : (req_valid & owner_mask);
        grant_lock      = req_lock[grant_idx];
        grant_data      = req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        ptr_after_grant = IDX_WIDTH'(std_wrap_inc(32'(grant_idx), PORTS));
        ptr_after_owner = IDX_WIDTH'(std_wrap_inc(32'(lock_owner), PORTS));
    end

    std_round_robin_picker #(
        .PORTS     (PORTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .req       (eff_req),
        .ptr       (ptr),
        .enable    (~stall),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    // Storage, pointer, lock FSM and watchdog; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= STD_REG_ARB_ARB;
            ptr          <= '0;
            cnt          <= '0;
            value        <= RESET_VECTOR;
            update       <= 1'b0;
            writer       <= '0;
            locked       <= 1'b0;
            lock_owner   <= '0;
            lock_timeout <= 1'b0;
        end else begin
            update       <= 1'b0;
            lock_timeout <= 1'b0;

            if (any_grant) begin
                value  <= grant_data;
                writer <= grant_idx;
                update <= 1'b1;
            end

            case (state)
                STD_REG_ARB_ARB: begin
                    if (any_grant) begin
                        ptr <= ptr_after_grant;
                        if (grant_lock) begin
                            state      <= STD_REG_ARB_LOCKED;
                            locked     <= 1'b1;
                            lock_owner <= grant_idx;
                            cnt        <= '0;
                        end
                    end
                end

                STD_REG_ARB_LOCKED: begin
                    if (any_grant) begin
                        if (grant_lock) begin
                            cnt <= '0;
                        end else begin
                            state  <= STD_REG_ARB_ARB;
                            locked <= 1'b0;
                            ptr    <= ptr_after_owner;
                        end
                    end else if (!stall) begin
                        if (WD_EN && cnt == CNT_LAST) begin
                            state        <= STD_REG_ARB_ARB;
                            locked       <= 1'b0;
                            lock_timeout <= 1'b1;
                            ptr          <= ptr_after_owner;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                default: state <= STD_REG_ARB_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_std_register_arbiter.sv
// Directed bench for std_register_arbiter with a rule-level reference model
// and a per-cycle compare process.
module tb_std_register_arbiter;

    localparam int          P   = 4;
    localparam int          DW  = 32;
    localparam logic [31:0] RV  = 32'hA5;
    localparam int          LT  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic [P-1:0]    req_valid;
    logic [P-1:0]    req_lock;
    logic [P*DW-1:0] req_data;
    logic [P-1:0]    req_ready;
    logic [DW-1:0]   value;
    logic            update;
    logic [1:0]      writer;
    logic            locked;
    logic [1:0]      lock_owner;
    logic            lock_timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    std_register_arbiter #(
        .PORTS        (P),
        .DATA_WIDTH   (DW),
        .RESET_VECTOR (RV),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .req_valid    (req_valid),
        .req_lock     (req_lock),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .value        (value),
        .update       (update),
        .writer       (writer),
        .locked       (locked),
        .lock_owner   (lock_owner),
        .lock_timeout (lock_timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid = 0;
    bit          m_lock;
    int          m_owner, m_ptr, m_idle, m_writer;
    logic [31:0] m_value;
    bit          m_upd, m_to;

    function automatic logic [P-1:0] exp_ready();
        if (stall) return '0;
        if (m_lock) return req_valid[m_owner] ? (P'(1) << m_owner) : '0;
        for (int k = 0; k < P; k++) begin
            if (req_valid[(m_ptr + k) % P]) return P'(1) << ((m_ptr + k) % P);
        end
        return '0;
    endfunction

    always @(posedge clk) begin
        logic [P-1:0] r;
        int g;
        if (rst) begin
            m_valid = 1; m_lock = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
            m_writer = 0; m_value = RV; m_upd = 0; m_to = 0;
        end else if (m_valid) begin
            r = exp_ready();
            m_upd = 0; m_to = 0;
            if (r != 0) begin
                g = 0;
                for (int k = 0; k < P; k++) if (r[k]) g = k;
                m_value = req_data[g*DW +: DW]; m_writer = g; m_upd = 1;
                if (m_lock) begin
                    if (req_lock[g]) m_idle = 0;
                    else begin m_lock = 0; m_ptr = (g + 1) % P; end
                end else begin
                    m_ptr = (g + 1) % P;
                    if (req_lock[g]) begin m_lock = 1; m_owner = g; m_idle = 0; end
                end
            end else if (m_lock && !stall) begin
                m_idle++;
                if (m_idle == LT) begin m_lock = 0; m_to = 1; m_ptr = (m_owner + 1) % P; end
            end
        end
    end

    // Compare process: checks every cycle after the first reset.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready", 64'(req_ready), 64'(exp_ready()));
            chk("value", 64'(value), 64'(m_value));
            chk("update", 64'(update), 64'(m_upd));
            chk("writer", 64'(writer), 64'(m_writer));
            chk("locked", 64'(locked), 64'(m_lock));
            chk("lock_timeout", 64'(lock_timeout), 64'(m_to));
            if (m_lock) chk("lock_owner", 64'(lock_owner), 64'(m_owner));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic wait_timeout(output int n);
        n = 0;
        while (lock_timeout !== 1'b1 && n < 20) begin tick(); n++; end
    endtask

    int n;

    initial begin
        rst = 1; stall = 0; req_valid = '0; req_lock = '0; req_data = '0;
        tick(); tick();
        rst = 0;
        // 1: reset state
        #1;
        chk("t1_value", 64'(value), 64'h A5);
        chk("t1_update", 64'(update), 64'd0);
        chk("t1_locked", 64'(locked), 64'd0);
        chk("t1_ready", 64'(req_ready), 64'd0);
        tick();

        // 2: all valid, round robin 0,1,2,3,0
        for (int i = 0; i < P; i++) set_data(i, 32'h10 + 32'(i));
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t2_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk("t2_value", 64'(value), 64'(32'h10 + 32'(k % 4)));
            chk("t2_writer", 64'(writer), 64'(k % 4));
            chk("t2_update", 64'(update), 64'd1);
        end
        req_valid = '0; tick();

        // 3: port 2 lock, contended, release, then port 3 before port 0
        set_data(2, 32'h1); req_lock = 4'b0100; req_valid = 4'b0100;
        #1 chk("t3_lockgrant", 64'(req_ready), 64'b0100);
        tick();
        chk("t3_locked", 64'(locked), 64'd1);
        chk("t3_owner", 64'(lock_owner), 64'd2);
        set_data(0, 32'h77); set_data(2, 32'h2); req_lock = '0; req_valid = 4'b0101;
        #1 chk("t3_only_owner", 64'(req_ready), 64'b0100);
        tick();
        chk("t3_released", 64'(locked), 64'd0);
        chk("t3_value", 64'(value), 64'h2);
        set_data(3, 32'h33); req_valid = 4'b1001;
        #1 chk("t3_next_p3", 64'(req_ready), 64'b1000);
        tick();
        chk("t3_value3", 64'(value), 64'h33);
        #1 chk("t3_then_p0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0; tick();

        // 4: port 1 locks and idles until the watchdog fires
        set_data(1, 32'h5); req_lock = 4'b0010; req_valid = 4'b0010;
        tick();
        req_valid = '0; req_lock = '0;
        wait_timeout(n);
        chk("t4_timeout_cycles", 64'(n), 64'd4);
        chk("t4_unlocked", 64'(locked), 64'd0);
        req_valid = 4'b0001; set_data(0, 32'h44);
        #1 chk("t4_p0_grant", 64'(req_ready), 64'b0001);
        tick();
        chk("t4_value", 64'(value), 64'h44);
        req_valid = '0; tick();

        // 5: stall freezes the watchdog for 3 cycles
        req_lock = 4'b0010; req_valid = 4'b0010;
        tick();
        stall = 1;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t5_stall_ready", 64'(req_ready), 64'd0);
            tick(); n++;
        end
        stall = 0; req_valid = '0; req_lock = '0;
        begin
            int m;
            wait_timeout(m);
            n += m;
        end
        chk("t5_timeout_cycles", 64'(n), 64'd7);
        tick();

        // 6: reset while locked with a pending owner write
        set_data(3, 32'hCAFE); req_lock = 4'b1000; req_valid = 4'b1000;
        tick();
        chk("t6_locked", 64'(locked), 64'd1);
        rst = 1; set_data(3, 32'hBEEF); req_lock = '0;
        tick();
        rst = 0; req_valid = '0;
        chk("t6_value", 64'(value), 64'h A5);
        chk("t6_locked_clr", 64'(locked), 64'd0);
        chk("t6_update", 64'(update), 64'd0);
        for (int i = 0; i < P; i++) set_data(i, 32'h10 + 32'(i));
        req_valid = 4'hF;
        #1 chk("t6_ptr0", 64'(req_ready), 64'b0001);
        tick();
        chk("t6_value0", 64'(value), 64'h10);
        req_valid = '0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
